// File: rtl/pci_emu_target_gen2.sv
// Lane-serial host bus to 32-bit OPB bridge with ACK handshake, timeout and sticky error.
// Optional macro PCI_EMU_BURST_EN: chain accesses with OPB_ADDR auto-increment while CS stays low.
module pci_emu_target_gen2 #(
    parameter int unsigned AD_W        = 8,
    parameter int unsigned ADDR_LANES  = 3,
    parameter int unsigned DATA_LANES  = 4,
    parameter int unsigned BSEL_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              PCI_CLK2,
    input  logic              RESET_N,
    input  logic              CS,
    input  logic              ADDR_DATA_SEL,
    input  logic              RD_WR,
    input  logic [BSEL_W-1:0] BYTE_SEL,
    input  logic              BYTE_VLD,
    input  logic [AD_W-1:0]   AD_I,
    output logic [AD_W-1:0]   AD_O,
    output logic              AD_OE,
    output logic              RDY,
    output logic              ERR,
    input  logic [31:0]       OPB_DI,
    input  logic              OPB_ACK,
    output logic [31:0]       OPB_DO,
    output logic [31:0]       OPB_ADDR,
    output logic              OPB_RE,
    output logic              OPB_WE
);
    localparam int unsigned DW    = AD_W * DATA_LANES;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

`ifdef PCI_EMU_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ADDR       = 3'd1;
    localparam logic [2:0] S_WR_COLLECT = 3'd2;
    localparam logic [2:0] S_WR_REQ     = 3'd3;
    localparam logic [2:0] S_RD_REQ     = 3'd4;
    localparam logic [2:0] S_RD_HOLD    = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    logic [2:0]                      state_q, state_d;
    logic [ADDR_LANES-1:0][AD_W-1:0] addr_lane_q, addr_lane_d;
    logic [DATA_LANES-1:0][AD_W-1:0] wr_lane_q, wr_lane_d;
    logic [DATA_LANES-1:0][AD_W-1:0] rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]                tmo_cnt_q, tmo_cnt_d;
    logic [31:0]                     opb_addr_q, opb_addr_d;
    logic [31:0]                     opb_do_q, opb_do_d;
    logic                            re_q, re_d;
    logic                            we_q, we_d;
    logic [AD_W-1:0]                 ad_o_q, ad_o_d;
    logic                            ad_oe_q, ad_oe_d;
    logic                            rdy_q, rdy_d;
    logic                            err_q, err_d;
    logic                            tmo_hit_c;
    logic                            last_lane_c;

    // Timeout fires on the cycle the wait counter would reach TIMEOUT_CYC.
    assign tmo_hit_c   = (TIMEOUT_CYC != 0) && ((32'(tmo_cnt_q) + 32'd1) == TIMEOUT_CYC);
    assign last_lane_c = BYTE_VLD && (BYTE_SEL == BSEL_W'(DATA_LANES - 1));

    always_ff @(posedge PCI_CLK2) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_lane_q <= '0;
            wr_lane_q   <= '0;
            rd_buf_q    <= '0;
            tmo_cnt_q   <= '0;
            opb_addr_q  <= '0;
            opb_do_q    <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            ad_o_q      <= '0;
            ad_oe_q     <= 1'b0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lane_q <= addr_lane_d;
            wr_lane_q   <= wr_lane_d;
            rd_buf_q    <= rd_buf_d;
            tmo_cnt_q   <= tmo_cnt_d;
            opb_addr_q  <= opb_addr_d;
            opb_do_q    <= opb_do_d;
            re_q        <= re_d;
            we_q        <= we_d;
            ad_o_q      <= ad_o_d;
            ad_oe_q     <= ad_oe_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_lane_d = addr_lane_q;
        wr_lane_d   = wr_lane_q;
        rd_buf_d    = rd_buf_q;
        tmo_cnt_d   = tmo_cnt_q;
        opb_addr_d  = opb_addr_q;
        opb_do_d    = opb_do_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        ad_o_d      = ad_o_q;
        ad_oe_d     = 1'b0;
        rdy_d       = 1'b0;
        err_d       = err_q;

        if (CS) begin
            // Deselect abandons whatever is in flight, including a pending OPB request.
            state_d = S_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ADDR;

                S_ADDR: begin
                    if (ADDR_DATA_SEL) begin
                        // Direction is taken from RD_WR here and carried by the state thereafter.
                        opb_addr_d = 32'(addr_lane_q);
                        tmo_cnt_d  = '0;
                        if (RD_WR) begin
                            state_d = S_RD_REQ;
                            re_d    = 1'b1;
                        end else begin
                            state_d = S_WR_COLLECT;
                        end
                    end else if (BYTE_VLD) begin
                        for (int i = 0; i < int'(ADDR_LANES); i++) begin
                            if (BYTE_SEL == BSEL_W'(i)) addr_lane_d[i] = AD_I;
                        end
                    end
                end

                S_WR_COLLECT: begin
                    if (BYTE_VLD) begin
                        for (int i = 0; i < int'(DATA_LANES); i++) begin
                            if (BYTE_SEL == BSEL_W'(i)) wr_lane_d[i] = AD_I;
                        end
                    end
                    if (last_lane_c) begin
                        opb_do_d  = 32'(wr_lane_d);
                        we_d      = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = S_WR_REQ;
                    end
                end

                S_WR_REQ: begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    if (OPB_ACK || tmo_hit_c) begin
                        if (!OPB_ACK) err_d = 1'b1;
                        if (BURST_EN) begin
                            opb_addr_d = opb_addr_q + 32'(DATA_LANES);
                            state_d    = S_WR_COLLECT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        we_d = 1'b1;
                    end
                end

                S_RD_REQ: begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    if (OPB_ACK) begin
                        rd_buf_d = DW'(OPB_DI);
                        rdy_d    = 1'b1;
                        state_d  = S_RD_HOLD;
                    end else if (tmo_hit_c) begin
                        rd_buf_d = '1;
                        err_d    = 1'b1;
                        rdy_d    = 1'b1;
                        state_d  = S_RD_HOLD;
                    end else begin
                        re_d = 1'b1;
                    end
                end

                S_RD_HOLD: begin
                    rdy_d = 1'b1;
                    if (ADDR_DATA_SEL) begin
                        ad_oe_d = 1'b1;
                        ad_o_d  = '0;
                        for (int i = 0; i < int'(DATA_LANES); i++) begin
                            if (BYTE_SEL == BSEL_W'(i)) ad_o_d = rd_buf_q[i];
                        end
                    end
                    // Last lane still drives AD_O for one cycle while the read retires.
                    if (last_lane_c) begin
                        rdy_d = 1'b0;
                        if (BURST_EN) begin
                            opb_addr_d = opb_addr_q + 32'(DATA_LANES);
                            tmo_cnt_d  = '0;
                            re_d       = 1'b1;
                            state_d    = S_RD_REQ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end

                S_DONE: state_d = S_DONE;

                default: state_d = S_IDLE;
            endcase
        end
    end

    assign AD_O     = ad_o_q;
    assign AD_OE    = ad_oe_q;
    assign RDY      = rdy_q;
    assign ERR      = err_q;
    assign OPB_DO   = opb_do_q;
    assign OPB_ADDR = opb_addr_q;
    assign OPB_RE   = re_q;
    assign OPB_WE   = we_q;

endmodule
